// File: rtl/memstream_loader_if.sv
// Reload control, weight stream and memstream config-port signals for memstream_loader.
// master is the loader side; slave is the host/DMA/memory side.
interface memstream_loader_if #(
    parameter int unsigned MEM_WIDTH = 32
);
    localparam int unsigned TDATA_W = ((MEM_WIDTH + 7) / 8) * 8;

    logic               start;
    logic [31:0]        base_addr;
    logic [31:0]        word_count;
    logic               busy;
    logic               done;
    logic               err;
    logic               strm_hold;

    logic               s_axis_tvalid;
    logic               s_axis_tready;
    logic [TDATA_W-1:0] s_axis_tdata;

    logic [31:0]        config_address;
    logic               config_ce;
    logic               config_we;
    logic [31:0]        config_d0;

    modport master (
        input  start, base_addr, word_count,
        output busy, done, err, strm_hold,
        input  s_axis_tvalid, s_axis_tdata,
        output s_axis_tready,
        output config_address, config_ce, config_we, config_d0
    );

    modport slave (
        output start, base_addr, word_count,
        input  busy, done, err, strm_hold,
        output s_axis_tvalid, s_axis_tdata,
        input  s_axis_tready,
        input  config_address, config_ce, config_we, config_d0
    );
endinterface

// File: rtl/memstream_loader.sv
// Runtime weight-reload controller: pauses memstream readers, drains the read pipe, then
// streams AXI-Stream words into the config write port and pulses done when finished.
module memstream_loader #(
    parameter int unsigned MEM_DEPTH    = 13824,
    parameter int unsigned MEM_WIDTH    = 32,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input logic                aclk,
    input logic                areset,
    memstream_loader_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StLoad,
        StFlush
    } state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] remaining_q;
    logic [31:0] drain_q;

    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        hold_q;
    logic        wr_q;
    logic [31:0] cfg_addr_q;
    logic [31:0] cfg_d0_q;

    logic [32:0] end_addr;
    logic        req_bad;
    logic        tready;
    logic        beat;

    // 33-bit sum so a wrapping base+count is still rejected.
    assign end_addr = {1'b0, bus.base_addr} + {1'b0, bus.word_count};
    assign req_bad  = (bus.word_count == 32'd0) || (end_addr > 33'(MEM_DEPTH));

    assign tready = (state_q == StLoad) && (remaining_q != 32'd0);
    assign beat   = tready && bus.s_axis_tvalid;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= StIdle;
            addr_q      <= 32'd0;
            remaining_q <= 32'd0;
            drain_q     <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            hold_q      <= 1'b0;
            wr_q        <= 1'b0;
            cfg_addr_q  <= 32'd0;
            cfg_d0_q    <= 32'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            wr_q   <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (req_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q      <= bus.base_addr;
                            remaining_q <= bus.word_count;
                            drain_q     <= 32'(DRAIN_CYCLES);
                            busy_q      <= 1'b1;
                            hold_q      <= 1'b1;
                            state_q     <= StDrain;
                        end
                    end
                end

                StDrain: begin
                    // Leave on the cycle the counter would hit zero: DRAIN_CYCLES cycles here.
                    if (drain_q <= 32'd1) begin
                        drain_q <= 32'd0;
                        state_q <= StLoad;
                    end else begin
                        drain_q <= drain_q - 32'd1;
                    end
                end

                StLoad: begin
                    if (beat) begin
                        wr_q        <= 1'b1;
                        cfg_addr_q  <= addr_q;
                        cfg_d0_q    <= 32'(bus.s_axis_tdata[MEM_WIDTH-1:0]);
                        addr_q      <= addr_q + 32'd1;
                        remaining_q <= remaining_q - 32'd1;
                        if (remaining_q == 32'd1) begin
                            state_q <= StFlush;
                        end
                    end
                end

                StFlush: begin
                    state_q <= StIdle;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    hold_q  <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.strm_hold      = hold_q;
    assign bus.s_axis_tready  = tready;
    assign bus.config_address = cfg_addr_q;
    assign bus.config_ce      = wr_q;
    assign bus.config_we      = wr_q;
    assign bus.config_d0      = cfg_d0_q;

endmodule

// File: tb/tb_memstream_loader.sv
// Directed bench for memstream_loader: reload sequencing, bounds errors, ignored starts,
// asynchronous abort and overflow rejection.
module tb_memstream_loader;

    localparam int unsigned MEM_DEPTH    = 13824;
    localparam int unsigned MEM_WIDTH    = 32;
    localparam int unsigned DRAIN_CYCLES = 4;

    logic aclk;
    logic areset;
    int   errors;
    int   checks;

    memstream_loader_if #(.MEM_WIDTH(MEM_WIDTH)) bus ();

    memstream_loader #(
        .MEM_DEPTH   (MEM_DEPTH),
        .MEM_WIDTH   (MEM_WIDTH),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .aclk  (aclk),
        .areset(areset),
        .bus   (bus.master)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] c);
        bus.start      = 1'b1;
        bus.base_addr  = b;
        bus.word_count = c;
        tick();
        bus.start      = 1'b0;
    endtask

    // Present one word while in LOAD, then check the write it produces one cycle later.
    task automatic beat(input string tag, input logic [31:0] data, input logic [31:0] addr);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = data;
        chk({tag, "_tready"}, 32'(bus.s_axis_tready), 32'd1);
        tick();
        chk({tag, "_ce"}, 32'(bus.config_ce), 32'd1);
        chk({tag, "_we"}, 32'(bus.config_we), 32'd1);
        chk({tag, "_addr"}, bus.config_address, addr);
        chk({tag, "_d0"}, bus.config_d0, data);
        chk({tag, "_hold"}, 32'(bus.strm_hold), 32'd1);
    endtask

    initial begin
        int n;
        logic [4:0] pat;

        errors = 0;
        checks = 0;
        areset = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.word_count = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata = '0;
        repeat (2) tick();

        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_hold", 32'(bus.strm_hold), 32'd0);
        chk("rst_tready", 32'(bus.s_axis_tready), 32'd0);
        chk("rst_ce", 32'(bus.config_ce), 32'd0);
        chk("rst_addr", bus.config_address, 32'd0);
        chk("rst_d0", bus.config_d0, 32'd0);
        areset = 1'b0;
        tick();

        // 1: base 0, count 4, tvalid held high from before start.
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 32'hA0;
        do_start(32'd0, 32'd4);
        chk("t1_hold", 32'(bus.strm_hold), 32'd1);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < int'(DRAIN_CYCLES); i++) begin
            chk("t1_drain_tready", 32'(bus.s_axis_tready), 32'd0);
            chk("t1_drain_ce", 32'(bus.config_ce), 32'd0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            beat("t1", 32'hA0 + 32'(i), 32'(i));
        end
        chk("t1_flush_tready", 32'(bus.s_axis_tready), 32'd0);
        chk("t1_flush_done", 32'(bus.done), 32'd0);
        bus.s_axis_tvalid = 1'b0;
        tick();
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_busy_off", 32'(bus.busy), 32'd0);
        chk("t1_hold_off", 32'(bus.strm_hold), 32'd0);
        chk("t1_ce_off", 32'(bus.config_ce), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(bus.done), 32'd0);

        // 2: base 100, count 3, tvalid 1,0,1,0,1.
        do_start(32'd100, 32'd3);
        repeat (DRAIN_CYCLES) tick();
        pat = 5'b10101;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            bus.s_axis_tvalid = pat[k];
            bus.s_axis_tdata  = 32'hB0 + 32'(k);
            chk("t2_tready", 32'(bus.s_axis_tready), 32'd1);
            tick();
            chk("t2_ce", 32'(bus.config_ce), 32'(pat[k]));
            if (pat[k]) begin
                chk("t2_addr", bus.config_address, 32'd100 + 32'(n));
                chk("t2_d0", bus.config_d0, 32'hB0 + 32'(k));
                n++;
            end
        end
        bus.s_axis_tvalid = 1'b0;
        chk("t2_no_early_done", 32'(bus.done), 32'd0);
        tick();
        chk("t2_done", 32'(bus.done), 32'd1);
        tick();
        chk("t2_done_once", 32'(bus.done), 32'd0);

        // 3: top-of-memory bounds.
        do_start(32'd13822, 32'd2);
        chk("t3_accept_err", 32'(bus.err), 32'd0);
        repeat (DRAIN_CYCLES) tick();
        beat("t3a", 32'hC0, 32'd13822);
        beat("t3b", 32'hC1, 32'd13823);
        bus.s_axis_tvalid = 1'b0;
        tick();
        chk("t3_done", 32'(bus.done), 32'd1);
        do_start(32'd13823, 32'd2);
        chk("t3_oob_err", 32'(bus.err), 32'd1);
        chk("t3_oob_busy", 32'(bus.busy), 32'd0);
        chk("t3_oob_hold", 32'(bus.strm_hold), 32'd0);
        tick();
        chk("t3_err_pulse", 32'(bus.err), 32'd0);
        chk("t3_oob_busy2", 32'(bus.busy), 32'd0);
        do_start(32'd5, 32'd0);
        chk("t3_zero_err", 32'(bus.err), 32'd1);
        chk("t3_zero_busy", 32'(bus.busy), 32'd0);
        tick();

        // 4: start during LOAD is ignored.
        do_start(32'd200, 32'd3);
        repeat (DRAIN_CYCLES) tick();
        beat("t4a", 32'hD0, 32'd200);
        bus.start      = 1'b1;
        bus.base_addr  = 32'd500;
        bus.word_count = 32'd1;
        beat("t4b", 32'hD1, 32'd201);
        bus.start = 1'b0;
        chk("t4_no_err", 32'(bus.err), 32'd0);
        beat("t4c", 32'hD2, 32'd202);
        bus.s_axis_tvalid = 1'b0;
        tick();
        chk("t4_done", 32'(bus.done), 32'd1);
        chk("t4_busy_off", 32'(bus.busy), 32'd0);
        tick();
        chk("t4_idle_tready", 32'(bus.s_axis_tready), 32'd0);

        // 5: asynchronous abort after 2 of 5 writes, then a clean restart.
        do_start(32'd300, 32'd5);
        repeat (DRAIN_CYCLES) tick();
        beat("t5a", 32'hE0, 32'd300);
        beat("t5b", 32'hE1, 32'd301);
        #1 areset = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_hold", 32'(bus.strm_hold), 32'd0);
        chk("t5_rst_ce", 32'(bus.config_ce), 32'd0);
        chk("t5_rst_we", 32'(bus.config_we), 32'd0);
        chk("t5_rst_addr", bus.config_address, 32'd0);
        chk("t5_rst_d0", bus.config_d0, 32'd0);
        chk("t5_rst_tready", 32'(bus.s_axis_tready), 32'd0);
        chk("t5_rst_done", 32'(bus.done), 32'd0);
        bus.s_axis_tvalid = 1'b0;
        #2 areset = 1'b0;
        tick();
        chk("t5_no_done", 32'(bus.done), 32'd0);
        chk("t5_idle_busy", 32'(bus.busy), 32'd0);
        do_start(32'd10, 32'd1);
        chk("t5_re_hold", 32'(bus.strm_hold), 32'd1);
        repeat (DRAIN_CYCLES - 1) tick();
        chk("t5_re_drain_tready", 32'(bus.s_axis_tready), 32'd0);
        tick();
        beat("t5c", 32'hF0, 32'd10);
        bus.s_axis_tvalid = 1'b0;
        tick();
        chk("t5_re_done", 32'(bus.done), 32'd1);

        // 6: base+count wraps 32 bits.
        do_start(32'hFFFF_FFFF, 32'd2);
        chk("t6_err", 32'(bus.err), 32'd1);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_ce", 32'(bus.config_ce), 32'd0);
        tick();
        chk("t6_ce_after", 32'(bus.config_ce), 32'd0);
        chk("t6_hold", 32'(bus.strm_hold), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
